// File: rtl/sa_feeder.sv
// Feeds the systolic grid: buffers a weight tile, bursts it north with o_sel high,
// then streams activation vectors west through a per-row skew line.
module sa_feeder #(
  parameter int ROWS      = 9,
  parameter int COLS      = 3,
  parameter int LOAD_HOLD = 1,
  parameter int DRAIN_CYC = ROWS + COLS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 s_w_valid,
  output logic                 s_w_ready,
  input  logic [COLS*8-1:0]    s_w_data,
  input  logic                 s_a_valid,
  output logic                 s_a_ready,
  input  logic [ROWS*8-1:0]    s_a_data,
  input  logic                 s_a_last,
  output logic                 o_sel,
  output logic [COLS*32-1:0]   o_north_data,
  output logic [ROWS*9-1:0]    o_west_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HOLD_W = $clog2(LOAD_HOLD + 1);
  localparam int PH_W   = $clog2(DRAIN_CYC + ROWS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WLOAD,
    STREAM,
    FLUSH,
    DRAIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   w_cnt;
  logic [IDX_W-1:0]   load_row;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PH_W-1:0]    phase_cnt;
  logic [COLS*8-1:0]  w_buf [ROWS];
  logic               a_fire;

  assign a_fire = s_a_valid && s_a_ready;
  assign o_busy = (state != IDLE);

  // Each weight byte becomes a zero-padded 32-bit north lane, col 0 in the MSBs.
  function automatic logic [COLS*32-1:0] widen_row(input logic [COLS*8-1:0] w);
    logic [COLS*32-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      v[(COLS-c)*32-1 -: 32] = {24'd0, w[(COLS-c)*8-1 -: 8]};
    end
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      w_cnt        <= '0;
      load_row     <= '0;
      hold_cnt     <= '0;
      phase_cnt    <= '0;
      s_w_ready    <= 1'b0;
      s_a_ready    <= 1'b0;
      o_sel        <= 1'b0;
      o_north_data <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= WFILL;
            w_cnt     <= '0;
            s_w_ready <= 1'b1;
          end
        end

        // The last beat goes straight onto the north bus, so the burst starts
        // without waiting for the buffer write to land.
        WFILL: begin
          if (s_w_valid && s_w_ready) begin
            w_buf[w_cnt[IDX_W-1:0]] <= s_w_data;
            if (w_cnt == CNT_W'(ROWS - 1)) begin
              s_w_ready    <= 1'b0;
              state        <= WLOAD;
              o_sel        <= 1'b1;
              o_north_data <= widen_row(s_w_data);
              load_row     <= IDX_W'(ROWS - 1);
              hold_cnt     <= '0;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end

        WLOAD: begin
          if (hold_cnt == HOLD_W'(LOAD_HOLD - 1)) begin
            hold_cnt <= '0;
            if (load_row == '0) begin
              state        <= STREAM;
              o_sel        <= 1'b0;
              o_north_data <= '0;
              s_a_ready    <= 1'b1;
            end else begin
              load_row     <= load_row - 1'b1;
              o_north_data <= widen_row(w_buf[load_row - 1'b1]);
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        STREAM: begin
          if (a_fire && s_a_last) begin
            s_a_ready <= 1'b0;
            phase_cnt <= '0;
            if (ROWS > 1) begin
              state <= FLUSH;
            end else begin
              state <= DRAIN;
            end
          end
        end

        FLUSH: begin
          if (phase_cnt == PH_W'(ROWS - 2)) begin
            phase_cnt <= '0;
            state     <= DRAIN;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (phase_cnt == PH_W'(DRAIN_CYC - 1)) begin
            phase_cnt <= '0;
            state     <= IDLE;
            o_done    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Row r gets an (r+1)-deep shift line; a bubble enters whenever no vector is taken.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [8:0] pipe [0:r];
    logic [8:0] token;

    assign token = a_fire ? {1'b1, s_a_data[(ROWS-r)*8-1 -: 8]} : 9'd0;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int s = 0; s <= r; s++) begin
          pipe[s] <= '0;
        end
      end else begin
        pipe[0] <= token;
        for (int s = 1; s <= r; s++) begin
          pipe[s] <= pipe[s-1];
        end
      end
    end

    assign o_west_data[(ROWS-r)*9-1 -: 9] = pipe[r];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: random weight/activation jobs checked against a
// cycle-indexed token history and the phase timing of a job.
module tb_sa_feeder;

  localparam int ROWS      = 3;
  localparam int COLS      = 2;
  localparam int LOAD_HOLD = 1;
  localparam int DRAIN_CYC = ROWS + COLS;

  typedef logic [COLS*8-1:0]  wvec_t;
  typedef logic [ROWS*8-1:0]  avec_t;
  typedef logic [COLS*32-1:0] nvec_t;
  typedef logic [ROWS*9-1:0]  tvec_t;

  logic  i_clk = 1'b0;
  logic  i_rst;
  logic  i_start;
  logic  s_w_valid;
  logic  s_w_ready;
  wvec_t s_w_data;
  logic  s_a_valid;
  logic  s_a_ready;
  avec_t s_a_data;
  logic  s_a_last;
  logic  o_sel;
  nvec_t o_north_data;
  tvec_t o_west_data;
  logic  o_busy;
  logic  o_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Whether the model believes the feeder is taking vectors this cycle, and
  // the token vector issued on each cycle since the last reset.
  bit    exp_a_ready = 1'b0;
  tvec_t tokq[$];

  sa_feeder #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .LOAD_HOLD (LOAD_HOLD),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .s_w_valid    (s_w_valid),
    .s_w_ready    (s_w_ready),
    .s_w_data     (s_w_data),
    .s_a_valid    (s_a_valid),
    .s_a_ready    (s_a_ready),
    .s_a_data     (s_a_data),
    .s_a_last     (s_a_last),
    .o_sel        (o_sel),
    .o_north_data (o_north_data),
    .o_west_data  (o_west_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs weight bytes into north lanes by shifting columns in from col 0 upward.
  function automatic nvec_t expNorth(input wvec_t w);
    nvec_t v = '0;
    for (int c = 0; c < COLS; c++) begin
      v = (v << 32) | nvec_t'(w[(COLS-1-c)*8 +: 8]);
    end
    return v;
  endfunction

  // One clock: log this cycle's token, step past the edge, compare the west bus
  // with tokens issued r+1 cycles back for each row r.
  task automatic applyStimulus();
    tvec_t tok = '0;
    tvec_t west_exp = '0;
    tvec_t past;
    bit    rst_edge = i_rst;
    if (exp_a_ready && s_a_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        tok[(ROWS-r)*9-1 -: 9] = {1'b1, s_a_data[(ROWS-r)*8-1 -: 8]};
      end
    end
    @(posedge i_clk);
    #1;
    if (rst_edge) begin
      tokq.delete();
      exp_a_ready = 1'b0;
    end else begin
      tokq.push_back(tok);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (tokq.size() > r) begin
        past = tokq[tokq.size()-1-r];
        west_exp[(ROWS-r)*9-1 -: 9] = past[(ROWS-r)*9-1 -: 9];
      end
    end
    checkOutput("west", o_west_data, west_exp);
  endtask

  task automatic runJob(input bit directed, input int nvec, input int rst_at,
                        input bit restart_at_done, input bit skip_start);
    wvec_t w [ROWS];
    int    k;
    int    v;
    int    i;

    if (!skip_start) begin
      i_start = 1'b1;
      applyStimulus();
      i_start = 1'b0;
    end
    checkOutput("busy_after_start", o_busy, 1);
    checkOutput("w_ready_open", s_w_ready, 1);

    for (int r = 0; r < ROWS; r++) begin
      w[r] = directed ? wvec_t'(((2*r+1) << 8) | (2*r+2)) : wvec_t'($urandom);
    end

    k = 0;
    while (k < ROWS) begin
      s_w_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_w_data  = s_w_valid ? w[k] : wvec_t'($urandom);
      applyStimulus();
      if (s_w_valid) k++;
      if (k < ROWS) checkOutput("w_ready_fill", s_w_ready, 1);
    end

    // Extra weight beats offered during the burst must be refused.
    s_w_valid = directed;
    for (i = 0; i < ROWS*LOAD_HOLD; i++) begin
      s_w_data = wvec_t'($urandom);
      checkOutput("sel_burst", o_sel, 1);
      checkOutput("w_ready_closed", s_w_ready, 0);
      checkOutput("a_ready_load", s_a_ready, 0);
      checkOutput("north_row", o_north_data, expNorth(w[ROWS-1-i/LOAD_HOLD]));
      applyStimulus();
    end
    s_w_valid = 1'b0;
    checkOutput("sel_off", o_sel, 0);
    checkOutput("north_off", o_north_data, 0);
    checkOutput("a_ready_stream", s_a_ready, 1);
    exp_a_ready = 1'b1;

    v = 0;
    i = 0;
    while (v < nvec) begin
      if (v == rst_at) begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        s_a_valid = 1'b1;
        applyStimulus();
        i_rst     = 1'b0;
        s_a_valid = 1'b0;
        s_a_last  = 1'b0;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_sel", o_sel, 0);
        checkOutput("rst_north", o_north_data, 0);
        checkOutput("rst_w_ready", s_w_ready, 0);
        checkOutput("rst_a_ready", s_a_ready, 0);
        applyStimulus();
        checkOutput("rst_no_done", o_done, 0);
        checkOutput("rst_stay_idle", o_busy, 0);
        return;
      end
      s_a_valid = directed ? (i != 1) : ($urandom_range(0, 2) != 0);
      s_a_data  = (directed && v == 0) ? avec_t'(24'h112233) : avec_t'($urandom);
      s_a_last  = s_a_valid ? (v == nvec - 1) : 1'($urandom_range(0, 1));
      i_start   = 1'($urandom_range(0, 1));
      applyStimulus();
      if (s_a_valid) v++;
      i++;
      if (v == nvec) exp_a_ready = 1'b0;
      checkOutput("a_ready", s_a_ready, exp_a_ready);
      checkOutput("busy_stream", o_busy, 1);
    end

    // Skew flush plus drain: o_done lands ROWS+DRAIN_CYC cycles after the last beat.
    for (i = 0; i < ROWS + DRAIN_CYC - 1; i++) begin
      checkOutput("busy_drain", o_busy, 1);
      checkOutput("done_early", o_done, 0);
      checkOutput("a_ready_drain", s_a_ready, 0);
      s_a_valid = 1'($urandom_range(0, 1));
      s_a_last  = 1'($urandom_range(0, 1));
      s_a_data  = avec_t'($urandom);
      s_w_valid = 1'($urandom_range(0, 1));
      i_start   = 1'($urandom_range(0, 1));
      applyStimulus();
    end
    s_a_valid = 1'b0;
    s_a_last  = 1'b0;
    s_w_valid = 1'b0;
    checkOutput("done_pulse", o_done, 1);
    checkOutput("busy_at_done", o_busy, 0);
    checkOutput("sel_idle", o_sel, 0);
    checkOutput("north_idle", o_north_data, 0);
    i_start = restart_at_done;
    applyStimulus();
    i_start = 1'b0;
    checkOutput("done_single", o_done, 0);
    checkOutput("busy_restart", o_busy, restart_at_done);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_start   = 1'b0;
    s_w_valid = 1'b0;
    s_w_data  = '0;
    s_a_valid = 1'b0;
    s_a_data  = '0;
    s_a_last  = 1'b0;
    applyStimulus();
    applyStimulus();
    i_rst = 1'b0;

    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_sel", o_sel, 0);
    checkOutput("reset_north", o_north_data, 0);
    checkOutput("reset_w_ready", s_w_ready, 0);
    checkOutput("reset_a_ready", s_a_ready, 0);

    $display("[TB] directed job, restart in done cycle");
    runJob(1'b1, 4, -1, 1'b1, 1'b0);
    $display("[TB] random job entered from done cycle");
    runJob(1'b0, 6, -1, 1'b0, 1'b1);
    $display("[TB] reset during streaming");
    runJob(1'b0, 5, 2, 1'b0, 1'b0);
    $display("[TB] random jobs after reset");
    runJob(1'b0, 3, -1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      runJob(1'b0, $urandom_range(1, 8), -1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
